// File: rtl/snake_dir_input.sv
// Direction-key front end for the snake mover: 2-flop sync, per-key debounce, press arbitration, request store, reverse-safe commit.
// Optional SNAKE_DIR_QUEUE2_EN turns the single last-wins request into a 2-entry FIFO.
module snake_dir_input #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter logic [1:0] RESET_DIR       = 2'd0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] key_n,
    input  logic       set_dir,
    output logic [1:0] dir,
    output logic       req_pending,
    output logic [1:0] req_dir,
    output logic [3:0] key_press
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    stable_q, stable_d;
    logic [3:0]    key_press_q, key_press_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [1:0]    dir_q, dir_d;

    logic       press_vld;
    logic [1:0] press_dir;
    logic [1:0] rev_dir;

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        stable_d    = stable_q;
        key_press_d = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i]    = sync2_q[i];
                cnt_d[i]       = '0;
                key_press_d[i] = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        press_vld = |key_press_q;
        if (key_press_q[0])      press_dir = 2'd0;
        else if (key_press_q[1]) press_dir = 2'd1;
        else if (key_press_q[2]) press_dir = 2'd2;
        else                     press_dir = 2'd3;
        rev_dir = dir_q ^ 2'b11;
    end

`ifdef SNAKE_DIR_QUEUE2_EN
    logic [1:0] q0_q, q0_d, q1_q, q1_d;
    logic [1:0] qcnt_q, qcnt_d;
    logic       pop, push;
    logic [1:0] tail_dir;

    always_comb begin
        dir_d    = dir_q;
        q0_d     = q0_q;
        q1_d     = q1_q;
        qcnt_d   = qcnt_q;
        tail_dir = (qcnt_q == 2'd2) ? q1_q : q0_q;
        pop      = set_dir && (qcnt_q != 2'd0);
        push     = press_vld && !((qcnt_q != 2'd0) && (press_dir == tail_dir));
        if (pop) begin
            if (q0_q != rev_dir) dir_d = q0_q;
            q0_d   = q1_q;
            qcnt_d = qcnt_q - 1'b1;
        end
        // A push into a full queue replaces the tail rather than growing it.
        if (push) begin
            if (qcnt_d == 2'd0) q0_d = press_dir;
            else                q1_d = press_dir;
            if (qcnt_d != 2'd2) qcnt_d = qcnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q0_q   <= RESET_DIR;
            q1_q   <= RESET_DIR;
            qcnt_q <= '0;
        end else begin
            q0_q   <= q0_d;
            q1_q   <= q1_d;
            qcnt_q <= qcnt_d;
        end
    end

    assign req_dir     = q0_q;
    assign req_pending = (qcnt_q != 2'd0);
`else
    logic       pend_q, pend_d;
    logic [1:0] rdir_q, rdir_d;

    // Commit uses the pre-edge request; a press in the same cycle becomes the next request.
    always_comb begin
        dir_d  = dir_q;
        pend_d = pend_q;
        rdir_d = rdir_q;
        if (set_dir && pend_q) begin
            if (rdir_q != rev_dir) dir_d = rdir_q;
            pend_d = 1'b0;
        end
        if (press_vld) begin
            pend_d = 1'b1;
            rdir_d = press_dir;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q <= 1'b0;
            rdir_q <= RESET_DIR;
        end else begin
            pend_q <= pend_d;
            rdir_q <= rdir_d;
        end
    end

    assign req_dir     = rdir_q;
    assign req_pending = pend_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            stable_q    <= 4'b1111;
            key_press_q <= '0;
            dir_q       <= RESET_DIR;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q     <= key_n;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            key_press_q <= key_press_d;
            dir_q       <= dir_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign dir       = dir_q;
    assign key_press = key_press_q;
endmodule
